eat_event_gen: RTL and testbench
================================

EAT_EVENT_GEN -- requirements
Module: eat_event_gen

Interface
REQ-001 Parameter COOLDOWN_FRAMES, default 4, number of whole frames during which collisions are ignored after a reported eat; legal range 1..15.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 resetN  input  1  synchronous reset, active-high: asserted = 1, sampled on the rising edge of clk.
REQ-004 pixelX  input  11  current scan column.
REQ-005 pixelY  input  11  current scan row.
REQ-006 player_dr  input  1  player drawing request at the current pixel.
REQ-007 gold_dr  input  1  gold-bag drawing request at the current pixel.
REQ-008 dimond_dr  input  1  diamond drawing request at the current pixel.
REQ-009 player_eat_gold  output  1  one-clock pulse per reported gold eat; feeds the score path.
REQ-010 player_eat_dimond  output  1  one-clock pulse per reported diamond eat; feeds the score path.
REQ-011 eat_busy  output  1  high while in REPORT or COOLDOWN.

Function
REQ-012 fs_cond SHALL be (pixelX==0 && pixelY==0); frame_start SHALL be the rising edge of fs_cond (registered previous value), so (0,0) held for several clocks yields exactly one frame_start.
REQ-013 FSM states SHALL be COLLECT, REPORT, COOLDOWN.
REQ-014 In COLLECT, gold_hit SHALL set on any clock where player_dr && gold_dr; dimond_hit likewise with dimond_dr; both are sticky until cleared.
REQ-015 Collisions on the frame_start clock SHALL count toward the new frame, not the ending one.
REQ-016 On frame_start in COLLECT with neither hit set: stay COLLECT, latches remain clear.
REQ-017 On frame_start in COLLECT with any hit set: capture gold_hit/dimond_hit into report registers, clear the latches (then apply REQ-015), go to REPORT.
REQ-018 REPORT SHALL last exactly one clock; player_eat_gold/player_eat_dimond SHALL equal the captured bits during that clock, else 0; latency from frame_start clock to pulse = 1 clock.
REQ-019 Gold and diamond captured in the same frame SHALL pulse on the same clock.
REQ-020 REPORT -> COOLDOWN unconditionally; cooldown counter (4 bits) loaded with COOLDOWN_FRAMES.
REQ-021 In COOLDOWN, hit latches SHALL be held clear and collisions ignored; each frame_start decrements the counter; the frame_start that decrements it from 1 to 0 SHALL move the FSM to COLLECT, and collisions on that clock SHALL be latched (REQ-015).
REQ-022 A frame_start during REPORT cannot occur (previous frame_start was 1 clock earlier, edge-detected); no handling required beyond staying deterministic (go to COOLDOWN).
REQ-023 Counter SHALL never underflow; value 0 only in COLLECT.
REQ-024 Multiple collision clocks within one frame SHALL produce at most one pulse per output.

Reset
REQ-025 While resetN=1 at a clock edge: state=COLLECT, hit latches=0, report registers=0, counter=0, previous fs_cond=1 (suppresses a false frame_start on the first clock after reset if scan sits at (0,0)).
REQ-026 Outputs after reset: player_eat_gold=0, player_eat_dimond=0, eat_busy=0; reset mid-REPORT SHALL suppress the pending pulse.

Structure
REQ-027 State enum (COLLECT/REPORT/COOLDOWN) and the 11-bit pixel coordinate width SHALL live in the shared game package.
REQ-028 The frame-start edge detector SHALL be a sub-module named frame_start_det (inputs clk, resetN, pixelX, pixelY; output frame_start), reusable by other per-frame blocks.
REQ-029 Single clock domain; no combinational path from *_dr inputs to outputs.

Verification
REQ-030 Player overlaps gold for 10 clocks in frame 1 -> exactly one player_eat_gold pulse, 1 clock after frame 2 start; eat_busy high from that clock for 4 frames.
REQ-031 Gold and diamond overlaps in same frame -> both pulses on same clock, each width 1.
REQ-032 Diamond overlap repeated in every frame, COOLDOWN_FRAMES=4 -> pulses every 5th frame start (frames 1, 6, 11 ...), none in between.
REQ-033 Scan held at (0,0) for 3 clocks with a latched hit -> one pulse only; collision on the frame_start clock reported at the following frame start.
REQ-034 resetN pulsed on the REPORT clock -> no pulse, eat_busy=0, next frame collision reported normally.
REQ-035 No overlaps (player_dr and gold_dr high at disjoint pixels) for 20 frames -> outputs remain 0.

Source files
------------

// File: rtl/eat_event_gen_pkg.sv
// Shared game types: scan coordinate width, eat-FSM states and the hit-flag pair.
// Pure declarations; no logic and no timing.
package eat_event_gen_pkg;

  localparam int PIX_W = 11;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_COLLECT  = 2'd0,
    ST_REPORT   = 2'd1,
    ST_COOLDOWN = 2'd2
  } eat_state_t;

  typedef struct packed {
    logic gold;
    logic dimond;
  } hit_t;

  function automatic logic any_hit(input hit_t h);
    return h.gold | h.dimond;
  endfunction

endpackage

// File: rtl/frame_start_det.sv
// Frame-start strobe: rising edge of "scan at (0,0)"; combinational from pixel inputs.
// Latency 0 (one-clock strobe); no backpressure.
module frame_start_det
  import eat_event_gen_pkg::*;
(
  input  logic             clk,
  input  logic             resetN,
  input  logic [PIX_W-1:0] pixelX,
  input  logic [PIX_W-1:0] pixelY,
  output logic             frame_start
);

  logic w_fs_cond;
  logic r_fs_prev;

  assign w_fs_cond = (pixelX == '0) && (pixelY == '0);

  // Previous value resets high so a scan parked at (0,0) across reset gives no strobe.
  always_ff @(posedge clk) begin
    if (resetN) begin
      r_fs_prev <= 1'b1;
    end else begin
      r_fs_prev <= w_fs_cond;
    end
  end

  assign frame_start = w_fs_cond & ~r_fs_prev;

endmodule

// File: rtl/eat_event_gen.sv
// Per-frame eat reporter: latches player/gold/diamond overlaps, pulses once per frame, then cools down.
// Latency: pulse 1 clock after frame start; no backpressure (score path always accepts).
module eat_event_gen
  import eat_event_gen_pkg::*;
#(
  parameter int COOLDOWN_FRAMES = 4
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [PIX_W-1:0] pixelX,
  input  logic [PIX_W-1:0] pixelY,
  input  logic             player_dr,
  input  logic             gold_dr,
  input  logic             dimond_dr,
  output logic             player_eat_gold,
  output logic             player_eat_dimond,
  output logic             eat_busy
);

  eat_state_t             r_state;
  eat_state_t             w_next_state;
  hit_t                   r_hit;
  hit_t                   w_next_hit;
  hit_t                   r_rep;
  hit_t                   w_next_rep;
  logic       [CNT_W-1:0] r_cnt;
  logic       [CNT_W-1:0] w_next_cnt;
  hit_t                   w_coll;
  logic                   w_frame_start;

  frame_start_det u_fs_det (
    .clk         (clk),
    .resetN      (resetN),
    .pixelX      (pixelX),
    .pixelY      (pixelY),
    .frame_start (w_frame_start)
  );

  assign w_coll.gold   = player_dr & gold_dr;
  assign w_coll.dimond = player_dr & dimond_dr;

  always_ff @(posedge clk) begin
    if (resetN) begin
      r_state <= ST_COLLECT;
      r_hit   <= '0;
      r_rep   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_hit   <= w_next_hit;
      r_rep   <= w_next_rep;
      r_cnt   <= w_next_cnt;
    end
  end

  // Collisions on the frame-start clock always belong to the frame that is beginning.
  always_comb begin
    w_next_state = r_state;
    w_next_hit   = r_hit;
    w_next_rep   = r_rep;
    w_next_cnt   = r_cnt;
    unique case (r_state)
      ST_COLLECT: begin
        if (w_frame_start && any_hit(r_hit)) begin
          w_next_rep   = r_hit;
          w_next_hit   = w_coll;
          w_next_state = ST_REPORT;
        end else if (w_frame_start) begin
          w_next_hit = w_coll;
        end else begin
          w_next_hit = hit_t'(r_hit | w_coll);
        end
      end
      ST_REPORT: begin
        w_next_hit   = '0;
        w_next_cnt   = CNT_W'(COOLDOWN_FRAMES);
        w_next_state = ST_COOLDOWN;
      end
      ST_COOLDOWN: begin
        w_next_hit = '0;
        if (w_frame_start) begin
          if (r_cnt <= CNT_W'(1)) begin
            w_next_cnt   = '0;
            w_next_hit   = w_coll;
            w_next_state = ST_COLLECT;
          end else begin
            w_next_cnt = r_cnt - CNT_W'(1);
          end
        end
      end
      default: begin
        w_next_hit   = '0;
        w_next_cnt   = '0;
        w_next_state = ST_COLLECT;
      end
    endcase
  end

  // Outputs are gated by reset so a reset landing on the report clock swallows the pulse.
  assign player_eat_gold   = (r_state == ST_REPORT) & r_rep.gold   & ~resetN;
  assign player_eat_dimond = (r_state == ST_REPORT) & r_rep.dimond & ~resetN;
  assign eat_busy          = (r_state != ST_COLLECT) & ~resetN;

endmodule

// File: tb/tb_eat_event_gen.sv
// Bench for eat_event_gen: frame-level reference model checked every clock, plus literal pulse-timing checks.
module tb_eat_event_gen;

  localparam int COOL = 4;
  localparam int W    = 16;
  localparam int H    = 2;
  localparam int FR   = W * H;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] px, py;
  logic        pdr, gdr, ddr;
  logic        o_gold, o_dia, o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  eat_event_gen #(.COOLDOWN_FRAMES(COOL)) dut (
    .clk               (clk),
    .resetN            (rst),
    .pixelX            (px),
    .pixelY            (py),
    .player_dr         (pdr),
    .gold_dr           (gdr),
    .dimond_dr         (ddr),
    .player_eat_gold   (o_gold),
    .player_eat_dimond (o_dia),
    .eat_busy          (o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Frame-level reference: a report happens at the first frame start that finds a hit
  // accumulated since the last accepting frame start, then COOL frame starts are skipped.
  int   cyc = 0;
  logic m_pg = 1'b0, m_pd = 1'b0;
  int   m_cool = 0;
  logic m_hg = 1'b0, m_hd = 1'b0;
  logic m_prev00 = 1'b1;

  always @(posedge clk) begin
    logic at00, fs, cg, cd;
    cyc++;
    if (rst) begin
      m_pg = 0; m_pd = 0; m_cool = 0; m_hg = 0; m_hd = 0; m_prev00 = 1;
    end else begin
      at00 = (px == 0) && (py == 0);
      fs = at00 && !m_prev00;
      m_prev00 = at00;
      cg = pdr && gdr;
      cd = pdr && ddr;
      if (m_pg || m_pd) begin
        m_pg = 0; m_pd = 0; m_cool = COOL; m_hg = 0; m_hd = 0;
      end else if (m_cool > 0) begin
        if (fs) begin
          m_cool--;
          if (m_cool == 0) begin m_hg = cg; m_hd = cd; end
        end
      end else if (fs && (m_hg || m_hd)) begin
        m_pg = m_hg; m_pd = m_hd; m_hg = 0; m_hd = 0;
      end else begin
        m_hg = m_hg | cg;
        m_hd = m_hd | cd;
      end
    end
  end

  int n_g = 0, n_d = 0, n_busy = 0;
  int last_g_cyc = -1, last_d_cyc = -1;

  always @(negedge clk) begin
    logic eg, ed, eb;
    eg = !rst && m_pg;
    ed = !rst && m_pd;
    eb = !rst && (m_pg || m_pd || m_cool > 0);
    chk_int("player_eat_gold", int'(o_gold), int'(eg));
    chk_int("player_eat_dimond", int'(o_dia), int'(ed));
    chk_int("eat_busy", int'(o_busy), int'(eb));
    if (o_gold) begin n_g++; last_g_cyc = cyc; end
    if (o_dia)  begin n_d++; last_d_cyc = cyc; end
    if (o_busy) n_busy++;
  end

  task automatic drive(input int x, input int y, input logic p, input logic g,
                       input logic d, input logic r);
    px = 11'(x); py = 11'(y); pdr = p; gdr = g; ddr = d; rst = r;
    @(posedge clk);
    #1;
  endtask

  int fs_cyc = 0;

  // One frame of raster scan; overlaps placed at fixed pixel indices.
  task automatic run_frame(input int g_ov, input int d_ov, input int disj,
                           input int hold, input int fs_coll, input int rst_idx);
    logic p, g, d;
    for (int h = 0; h < hold; h++) begin
      if (h == 0) fs_cyc = cyc;
      drive(0, 0, (h == 0 && fs_coll != 0), (h == 0 && fs_coll != 0), 1'b0, 1'b0);
    end
    for (int i = 1; i < FR; i++) begin
      p = 0; g = 0; d = 0;
      if (i >= 3 && i < 3 + g_ov)   begin p = 1; g = 1; end
      if (i >= 20 && i < 20 + d_ov) begin p = 1; d = 1; end
      if (disj != 0) begin
        if (i >= 5 && i < 10)  p = 1;
        if (i >= 12 && i < 17) g = 1;
        if (i >= 24 && i < 28) d = 1;
      end
      drive(i % W, i / W, p, g, d, (i == rst_idx));
    end
  endtask

  task automatic empty_frames(input int n);
    for (int k = 0; k < n; k++) run_frame(0, 0, 0, 1, 0, -1);
  endtask

  int g0, d0, b0, fsa, fsb;

  initial begin
    rst = 1; px = 0; py = 0; pdr = 0; gdr = 0; ddr = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    #2;
    chk_int("reset_gold", int'(o_gold), 0);
    chk_int("reset_dimond", int'(o_dia), 0);
    chk_int("reset_busy", int'(o_busy), 0);

    // Ten-clock gold overlap in frame 1 -> single pulse one clock after frame 2 start.
    g0 = n_g; b0 = n_busy;
    run_frame(10, 0, 0, 1, 0, -1);
    run_frame(0, 0, 0, 1, 0, -1);
    fsa = fs_cyc;
    empty_frames(5);
    chk_int("s1_gold_pulses", n_g - g0, 1);
    chk_int("s1_latency", last_g_cyc - fsa, 1);
    chk_int("s1_busy_cycles", n_busy - b0, COOL * FR);

    // Gold and diamond in one frame pulse together, one clock wide each.
    g0 = n_g; d0 = n_d;
    run_frame(2, 3, 0, 1, 0, -1);
    run_frame(0, 0, 0, 1, 0, -1);
    fsa = fs_cyc;
    empty_frames(4);
    chk_int("s2_gold_pulses", n_g - g0, 1);
    chk_int("s2_dimond_pulses", n_d - d0, 1);
    chk_int("s2_same_clock", last_g_cyc, last_d_cyc);
    chk_int("s2_latency", last_d_cyc - fsa, 1);

    // Diamond every frame: reports only at frame starts 1, 6, 11.
    d0 = n_d;
    run_frame(0, 2, 0, 1, 0, -1);
    fsa = -1;
    for (int f = 1; f < 12; f++) begin
      run_frame(0, 2, 0, 1, 0, -1);
      if (f == 6) fsa = fs_cyc;
      if (f == 11) fsb = fs_cyc;
    end
    chk_int("s3_dimond_pulses", n_d - d0, 3);
    chk_int("s3_last_pulse", last_d_cyc - fsb, 1);
    chk_int("s3_period", fsb - fsa, 5 * FR);

    // Collision on the cooldown-exit frame start is kept and reported next frame.
    g0 = n_g;
    empty_frames(3);
    run_frame(0, 0, 0, 1, 1, -1);
    run_frame(0, 0, 0, 1, 0, -1);
    fsa = fs_cyc;
    empty_frames(4);
    chk_int("s4_exit_gold_pulses", n_g - g0, 1);
    chk_int("s4_exit_latency", last_g_cyc - fsa, 1);

    // Scan parked at (0,0) for 3 clocks with a pending hit -> one pulse.
    g0 = n_g;
    run_frame(1, 0, 0, 1, 0, -1);
    run_frame(0, 0, 0, 3, 1, -1);
    fsa = fs_cyc;
    empty_frames(4);
    chk_int("s5_hold_pulses", n_g - g0, 1);
    chk_int("s5_hold_latency", last_g_cyc - fsa, 1);

    // Frame-start collision in idle COLLECT belongs to the new frame.
    g0 = n_g;
    run_frame(0, 0, 0, 1, 1, -1);
    run_frame(0, 0, 0, 1, 0, -1);
    fsa = fs_cyc;
    empty_frames(4);
    chk_int("s6_fsclk_pulses", n_g - g0, 1);
    chk_int("s6_fsclk_latency", last_g_cyc - fsa, 1);

    // Reset on the report clock swallows the pulse; later eats report normally.
    g0 = n_g;
    run_frame(1, 0, 0, 1, 0, -1);
    b0 = n_busy;
    run_frame(0, 0, 0, 1, 0, 1);
    chk_int("s7_swallowed", n_g - g0, 0);
    chk_int("s7_busy_cycles", n_busy - b0, 0);
    run_frame(1, 0, 0, 1, 0, -1);
    run_frame(0, 0, 0, 1, 0, -1);
    fsa = fs_cyc;
    empty_frames(4);
    chk_int("s7_after_reset", n_g - g0, 1);
    chk_int("s7_after_latency", last_g_cyc - fsa, 1);

    // Player and items at disjoint pixels for 20 frames -> nothing.
    g0 = n_g; d0 = n_d; b0 = n_busy;
    for (int f = 0; f < 20; f++) run_frame(0, 0, 1, 1, 0, -1);
    chk_int("s8_gold", n_g - g0, 0);
    chk_int("s8_dimond", n_d - d0, 0);
    chk_int("s8_busy", n_busy - b0, 0);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
